ring_freq_counter: RTL and testbench
====================================

Name: ring_freq_counter

Overview:
Downstream consumer of the ring oscillator output; measures its frequency digitally. The asynchronous ring signal is synchronised into the clk domain and its rising edges are counted over a programmable gate window. The result is latched and presented one byte at a time on the dedicated outputs. Repeated measurement lets PVT drift and enable toggling be observed without a scope on the analog pin.

Parameters:
CNT_W, 16, edge-counter and result width; legal range 9..16.
SYNC_STAGES, 2, number of synchroniser flops on ring_in; minimum 2.
MIN_GATE_LOG, 4, gate length is 2^(MIN_GATE_LOG+gate_sel) clk cycles.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
ena  in  1  design enable; low = synchronous abort to IDLE
ring_in  in  1  ring oscillator output, asynchronous to clk
start  in  1  level input; a rising edge starts one measurement
continuous  in  1  when high, windows repeat back-to-back
gate_sel  in  3  gate length select, 16..2048 cycles at defaults
byte_sel  in  1  0 = result[7:0], 1 = result[CNT_W-1:8] zero-extended
data_out  out  8  selected byte of the result register
busy  out  1  high while in COUNT or DONE
valid  out  1  sticky; high from result latch until the next window starts
overflow  out  1  sticky with valid; the last result saturated

Behaviour:
- Reset (rst_n low at a clk edge) clears: the sync chain, the edge-detect flop, start_q, the counter, the timer, the result, valid and overflow. State goes to IDLE. All outputs read 0.
- Reset mid-window abandons the measurement; no partial result is latched.
- Synchroniser: ring_in passes through SYNC_STAGES flops, then a prev flop. Pulse rise = sync & ~prev.
- Ring edges reach rise after SYNC_STAGES+1 cycles. Measurable ring frequency is below clk/2; faster signals alias and that is documented as out of range.
- start_q registers start each cycle. go = (start & ~start_q) | continuous.
- FSM states:
  - IDLE: if ena & go -> COUNT. On entry to COUNT: load timer = 2^(MIN_GATE_LOG+gate_sel)-1, clear counter, clear valid and overflow. gate_sel is sampled only at this point.
  - COUNT: each cycle, if rise, counter += 1, saturating at all-ones. When counter is already all-ones and rise occurs, set ovf_int. Timer decrements each cycle. In the cycle timer==0, that cycle's rise is still counted, then -> DONE. The window is exactly 2^(MIN_GATE_LOG+gate_sel) cycles of rise sampling.
  - DONE (one cycle): result <= counter, overflow <= ovf_int, valid <= 1. Then -> COUNT (with reload as above) if ena & continuous, else -> IDLE.
- Continuous mode: one dead cycle (DONE) between windows. An edge arriving in the DONE cycle is not counted.
- start edges while busy are ignored. They are not queued.
- ena low in any state: -> IDLE next cycle, counter and timer cleared, result/valid/overflow retained.
- data_out is combinational from the result register and byte_sel. Its value is stable except in the cycle after DONE.
- busy = (state != IDLE).

Decomposition:
- Package ring_meas_pkg:
  - state enum {IDLE, COUNT, DONE}
  - MIN_GATE_LOG default
  - function gate_len(gate_sel) returning the timer reload value
- One sub-module, ring_edge_sync: synchroniser chain plus edge detector.
  - Ports: clk, rst_n, ring_in, rise.
  - Parameter: SYNC_STAGES.

Test Plan:
1. ring_in square wave, period 4 clk; gate_sel=0; pulse start -> busy for 17 cycles, then valid=1, data_out=0x04 (byte_sel=0), 0x00 (byte_sel=1), overflow=0.
2. ring_in period 2 clk; gate_sel=7 -> result 1024: byte_sel=0 gives 0x00, byte_sel=1 gives 0x04; overflow=0.
3. CNT_W=9, ring_in period 2, gate_sel=7 -> result 511 (0x1FF), overflow=1; the next normal window with gate_sel=0 -> result 8, overflow=0.
4. ring_in held 0, then held 1, gate_sel=1 -> result 0 in both cases. A constant-high ring_in contributes at most one edge, only if it rises inside the window.
5. continuous=1, ring_in period 4, gate_sel=0 -> valid rises every 17 cycles, each result = 4. Deassert continuous -> returns to IDLE after the current DONE.
6. Assert rst_n low for one cycle mid-COUNT -> all outputs 0 next cycle, state IDLE. Separately, drop ena mid-COUNT -> IDLE, previous result and valid retained.

Source files
------------

// File: rtl/ring_meas_pkg.sv
// Shared types and helpers for the ring oscillator frequency counter.
package ring_meas_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone
    } meas_state_e;

    localparam int unsigned DefaultMinGateLog = 4;

    // Timer reload for a window of 2^(min_log+sel) clk cycles.
    function automatic logic [31:0] gate_len(input logic [2:0] sel,
                                             input int unsigned min_log = DefaultMinGateLog);
        return (32'd1 << (min_log + 32'(sel))) - 32'd1;
    endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// Synchronises the asynchronous ring oscillator into clk and flags its rising edges.
module ring_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ring_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ring_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ring_freq_counter.sv
// Counts synchronised ring oscillator edges over a programmable gate window and
// presents the latched result a byte at a time.
module ring_freq_counter
    import ring_meas_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned MIN_GATE_LOG = DefaultMinGateLog
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       ring_in,
    input  logic       start,
    input  logic       continuous,
    input  logic [2:0] gate_sel,
    input  logic       byte_sel,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       valid,
    output logic       overflow
);

    // Wide enough for the largest reload, 2^(MIN_GATE_LOG+7)-1.
    localparam int unsigned TimerW = MIN_GATE_LOG + 7;

    meas_state_e       state_q, state_d;
    logic              start_q, start_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              ovf_int_q, ovf_int_d;
    logic [CNT_W-1:0]  result_q, result_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;
    logic              rise;
    logic              go;
    logic              load;

    ring_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .ring_in(ring_in),
        .rise   (rise)
    );

    always_comb begin
        state_d    = state_q;
        start_d    = start;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        ovf_int_d  = ovf_int_q;
        result_d   = result_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        load       = 1'b0;
        go         = (start & ~start_q) | continuous;

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    load       = 1'b1;
                    valid_d    = 1'b0;
                    overflow_d = 1'b0;
                end
            end
            StCount: begin
                // Clears the one-cycle valid left by a back-to-back DONE.
                valid_d    = 1'b0;
                overflow_d = 1'b0;
                if (rise) begin
                    if (&cnt_q) begin
                        ovf_int_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                timer_d = timer_q - 1'b1;
                if (timer_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                result_d   = cnt_q;
                overflow_d = ovf_int_q;
                valid_d    = 1'b1;
                if (continuous) begin
                    load = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            state_d   = StCount;
            timer_d   = TimerW'(gate_len(gate_sel, MIN_GATE_LOG));
            cnt_d     = '0;
            ovf_int_d = 1'b0;
        end

        // Abort wins over everything, including a DONE latch in flight.
        if (!ena) begin
            state_d    = StIdle;
            cnt_d      = '0;
            timer_d    = '0;
            ovf_int_d  = 1'b0;
            result_d   = result_q;
            valid_d    = valid_q;
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            cnt_q      <= '0;
            timer_q    <= '0;
            ovf_int_q  <= 1'b0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            ovf_int_q  <= ovf_int_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign data_out = byte_sel ? 8'(result_q[CNT_W-1:8]) : result_q[7:0];
    assign busy     = (state_q != StIdle);
    assign valid    = valid_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ring_freq_counter.sv
// Scoreboard bench: two counters (16-bit and 9-bit) share stimulus; expected results
// come from counting rising transitions of the recorded ring waveform.
module tb_ring_freq_counter;

    localparam int S    = 2;
    localparam int MGL  = 4;
    localparam int MAXC = 32768;

    typedef struct {
        int res16;
        int ovf16;
        int res9;
        int ovf9;
        int len;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n, ena, ring_in, start, continuous, byte_sel;
    logic [2:0]      gate_sel;
    logic [1:0][7:0] dout;
    logic [1:0]      bsy, vld, ovf;

    bit   ring_arr [MAXC];
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   last16, last9;
    exp_t sb[$];

    always #5 clk = ~clk;

    ring_freq_counter #(
        .CNT_W(16), .SYNC_STAGES(S), .MIN_GATE_LOG(MGL)
    ) u_dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ring_in(ring_in), .start(start),
        .continuous(continuous), .gate_sel(gate_sel), .byte_sel(byte_sel),
        .data_out(dout[0]), .busy(bsy[0]), .valid(vld[0]), .overflow(ovf[0])
    );

    ring_freq_counter #(
        .CNT_W(9), .SYNC_STAGES(S), .MIN_GATE_LOG(MGL)
    ) u_dut9 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ring_in(ring_in), .start(start),
        .continuous(continuous), .gate_sel(gate_sel), .byte_sel(byte_sel),
        .data_out(dout[1]), .busy(bsy[1]), .valid(vld[1]), .overflow(ovf[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_byte(input int r, input logic bs);
        return bs ? 32'((r >> 8) & 255) : 32'(r & 255);
    endfunction

    // Inputs assigned after step() are seen by the DUT at posedge number cyc.
    task automatic step();
        @(negedge clk);
        cyc++;
        ring_in = (cyc < MAXC) ? ring_arr[cyc] : 1'b0;
    endtask

    task automatic fill(input int from, input int to, input int mode, input int period);
        int run = 0;
        bit v   = ring_arr[from-1];
        for (int k = from; k <= to && k < MAXC; k++) begin
            case (mode)
                0: ring_arr[k] = 1'b0;
                1: ring_arr[k] = 1'b1;
                2: ring_arr[k] = ((k / (period / 2)) % 2) != 0;
                default: begin
                    if (run == 0) begin
                        v   = ~v;
                        run = int'($urandom_range(1, 6));
                    end
                    ring_arr[k] = v;
                    run--;
                end
            endcase
        end
    endtask

    // Rising transitions of the ring as seen after the synchroniser, over the n
    // sampling cycles that follow the window-start edge t0.
    function automatic int edges_in(input int t0, input int n);
        int c = 0;
        for (int t = t0 + 1; t <= t0 + n; t++) begin
            if (ring_arr[t-S] && !ring_arr[t-S-1]) c++;
        end
        return c;
    endfunction

    task automatic push_exp(input int t0, input int n, input int len);
        exp_t e;
        int   c = edges_in(t0, n);
        e.res16 = (c > 65535) ? 65535 : c;
        e.ovf16 = (c > 65535) ? 1 : 0;
        e.res9  = (c > 511) ? 511 : c;
        e.ovf9  = (c > 511) ? 1 : 0;
        e.len   = len;
        sb.push_back(e);
        last16 = e.res16;
        last9  = e.res9;
    endtask

    task automatic check_bytes(input string tag, input int r16, input int r9);
        byte_sel = 1'b0;
        #1;
        check({tag, "_lo16"}, 32'(dout[0]), exp_byte(r16, 1'b0));
        check({tag, "_lo9"}, 32'(dout[1]), exp_byte(r9, 1'b0));
        byte_sel = 1'b1;
        #1;
        check({tag, "_hi16"}, 32'(dout[0]), exp_byte(r16, 1'b1));
        check({tag, "_hi9"}, 32'(dout[1]), exp_byte(r9, 1'b1));
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) begin
            step();
            byte_sel = 1'($urandom);
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: %0d results still pending after %0d cycles",
                     tag, sb.size(), bound);
            sb.delete();
        end
        check_bytes(tag, last16, last9);
    endtask

    task automatic measure(input string tag, input int gsel, input int mode, input int period);
        int n = 1 << (MGL + gsel);
        int t0;
        fill(cyc + 1, cyc + n + 80, mode, period);
        repeat (8) step();
        step();
        gate_sel = 3'(gsel);
        start    = 1'b1;
        t0       = cyc;
        push_exp(t0, n, n + 1);
        // Mid-window start pulses and gate_sel changes must have no effect.
        for (int i = 0; i < n - 4; i++) begin
            step();
            byte_sel = 1'($urandom);
            start    = ($urandom_range(0, 7) == 0);
            gate_sel = 3'($urandom);
        end
        step();
        start = 1'b0;
        drain(tag, 60);
    endtask

    task automatic run_cont(input string tag, input int gsel, input int mode, input int period,
                            input int m);
        int n = 1 << (MGL + gsel);
        int t0;
        fill(cyc + 1, cyc + m * (n + 1) + 80, mode, period);
        repeat (8) step();
        step();
        gate_sel   = 3'(gsel);
        continuous = 1'b1;
        t0         = cyc;
        for (int j = 0; j < m; j++) push_exp(t0 + j * (n + 1), n, (j + 1) * (n + 1));
        // Drop continuous part-way through the last window.
        for (int i = 0; i < (m - 1) * (n + 1) + n / 2; i++) begin
            step();
            byte_sel = 1'($urandom);
        end
        continuous = 1'b0;
        drain(tag, n + 60);
    endtask

    task automatic abort_test(input string tag, input bit use_reset);
        int r16 = use_reset ? 0 : last16;
        int r9  = use_reset ? 0 : last9;
        fill(cyc + 1, cyc + 200, 2, 4);
        repeat (8) step();
        step();
        gate_sel = 3'd2;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        if (use_reset) rst_n = 1'b0;
        else ena = 1'b0;
        step();
        check({tag, "_busy16"}, 32'(bsy[0]), 0);
        check({tag, "_busy9"}, 32'(bsy[1]), 0);
        // Valid and overflow were already cleared when this window started.
        check({tag, "_valid16"}, 32'(vld[0]), 0);
        check({tag, "_valid9"}, 32'(vld[1]), 0);
        check({tag, "_ovf16"}, 32'(ovf[0]), 0);
        check({tag, "_ovf9"}, 32'(ovf[1]), 0);
        check_bytes(tag, r16, r9);
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (10) step();
        if (use_reset) begin
            last16 = 0;
            last9  = 0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   run = 0;
        logic pv0 = 1'b0;
        logic pv1 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (vld[0] && !pv0) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid16: result 0x%0h with nothing expected",
                             dout[0]);
                end else begin
                    e = sb.pop_front();
                    check("sb_data16", 32'(dout[0]), exp_byte(e.res16, byte_sel));
                    check("sb_ovf16", 32'(ovf[0]), 32'(e.ovf16));
                    check("sb_valid9_rise", 32'(vld[1] & ~pv1), 1);
                    check("sb_data9", 32'(dout[1]), exp_byte(e.res9, byte_sel));
                    check("sb_ovf9", 32'(ovf[1]), 32'(e.ovf9));
                    if (!bsy[0]) check("sb_busy_len", 32'(run), 32'(e.len));
                end
            end else if (vld[1] && !pv1) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid9: result 0x%0h with no matching valid16",
                         dout[1]);
            end
            run = bsy[0] ? run + 1 : 0;
            pv0 = vld[0];
            pv1 = vld[1];
        end
    end

    initial begin : watchdog
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        last16     = 0;
        last9      = 0;
        rst_n      = 1'b0;
        ena        = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        gate_sel   = 3'd0;
        byte_sel   = 1'b0;
        ring_in    = 1'b0;

        repeat (4) step();
        check("rst_busy16", 32'(bsy[0]), 0);
        check("rst_busy9", 32'(bsy[1]), 0);
        check("rst_valid16", 32'(vld[0]), 0);
        check("rst_valid9", 32'(vld[1]), 0);
        check("rst_ovf16", 32'(ovf[0]), 0);
        check("rst_ovf9", 32'(ovf[1]), 0);
        check_bytes("rst", 0, 0);
        rst_n = 1'b1;
        repeat (6) step();

        measure("sq4_g0", 0, 2, 4);
        measure("sq2_g7", 7, 2, 2);
        measure("sq2_g0", 0, 2, 2);
        measure("low_g1", 1, 0, 0);
        measure("high_g1", 1, 1, 0);
        run_cont("cont_sq4", 0, 2, 4, 4);
        abort_test("ena_drop", 1'b0);
        abort_test("mid_reset", 1'b1);
        measure("post_reset", 0, 2, 4);

        for (int i = 0; i < 20; i++) begin
            measure("rand", int'($urandom_range(0, 3)), 3, 0);
        end
        for (int i = 0; i < 2; i++) begin
            run_cont("rand_cont", int'($urandom_range(0, 2)), 3, 0, 3);
        end

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
